decode_stage: RTL and testbench

- Instruction decode stage for the RV32I/RV32M core, directly upstream of the execute ALU.
- Accepts a fetched instruction and its PC, then splits out opcode, funct3 and funct7.
- Builds the sign-extended immediate and reads rs1/rs2 from an internal 32x32 register file.
- Presents everything through one registered valid/ready pipeline slot; the register file's write port is driven by writeback.

---
 rtl/riscv_pkg.sv | 55 +++++
 rtl/reg_file.sv | 44 ++++
 rtl/decode_stage.sv | 148 ++++++++++++++
 tb/tb_decode_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I/M encoding constants, immediate formats and the decoded-instruction payload.
package riscv_pkg;

    localparam int unsigned XLEN_W = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN_W-1:0] pc;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [XLEN_W-1:0] imm;
        logic              illegal;
    } dec_t;

    // Sign-extended immediate for the given format; R-type and unknown give 0.
    function automatic logic [XLEN_W-1:0] imm_gen(imm_fmt_e fmt, logic [XLEN_W-1:0] i);
        case (fmt)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry integer register file: two async read ports, one sync write port, x0 hardwired to zero.
module reg_file
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_addr,
    output logic [XLEN-1:0]   rs1_data_c,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs2_data_c,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data
);

    localparam int unsigned NREGS = 32;

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_c;

    assign wr_c = wb_en && (wb_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_c) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Same-cycle writeback wins over the stored value when bypass is enabled.
    always_comb begin
        rs1_data_c = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs2_data_c = (rs2_addr == '0) ? '0 : regs[rs2_addr];
        if (BYPASS && wr_c && (wb_addr == rs1_addr)) rs1_data_c = wb_data;
        if (BYPASS && wr_c && (wb_addr == rs2_addr)) rs2_data_c = wb_data;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I/M decode stage: field split, immediate build and operand read behind one valid/ready slot.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          M_EXT     = 1'b1,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd_addr,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    dec_t            dec_c;
    dec_t            dec_q;
    logic            valid_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] rf_rs1_c;
    logic [XLEN-1:0] rf_rs2_c;
    logic            accept_c;
    logic            hold_c;
    logic            refresh_ok_c;

    reg_file #(
        .XLEN   (XLEN),
        .BYPASS (WB_BYPASS)
    ) u_reg_file (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr   (dec_c.rs1),
        .rs1_data_c (rf_rs1_c),
        .rs2_addr   (dec_c.rs2),
        .rs2_data_c (rf_rs2_c),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    assign in_ready     = !valid_q || out_ready;
    assign accept_c     = in_valid && in_ready && !flush;
    assign hold_c       = valid_q && !out_ready && !flush;
    assign refresh_ok_c = WB_BYPASS && wb_en && (wb_addr != '0);

    // Combinational decode of the offered instruction.
    always_comb begin
        imm_fmt_e fmt;
        logic     has_rd;
        logic     illegal;
        fmt     = IMM_NONE;
        has_rd  = 1'b1;
        illegal = 1'b0;
        dec_c   = '0;

        dec_c.pc     = in_pc;
        dec_c.opcode = in_instr[6:0];
        dec_c.funct3 = in_instr[14:12];
        dec_c.funct7 = in_instr[31:25];
        dec_c.rs1    = in_instr[19:15];
        dec_c.rs2    = in_instr[24:20];

        case (dec_c.opcode)
            OP_R: begin
                case (dec_c.funct7)
                    F7_BASE:   illegal = 1'b0;
                    F7_ALT:    illegal = !((dec_c.funct3 == 3'd0) || (dec_c.funct3 == 3'd5));
                    F7_MULDIV: illegal = !M_EXT;
                    default:   illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                fmt = IMM_I;
                if (dec_c.funct3 == 3'd1 && dec_c.funct7 != F7_BASE) illegal = 1'b1;
                if (dec_c.funct3 == 3'd5 && dec_c.funct7 != F7_BASE && dec_c.funct7 != F7_ALT)
                    illegal = 1'b1;
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: fmt = IMM_I;
            OP_STORE: begin
                fmt    = IMM_S;
                has_rd = 1'b0;
            end
            OP_BRANCH: begin
                fmt    = IMM_B;
                has_rd = 1'b0;
            end
            OP_LUI, OP_AUIPC: fmt = IMM_U;
            OP_JAL:           fmt = IMM_J;
            default:          illegal = 1'b1;
        endcase

        dec_c.imm     = imm_gen(fmt, in_instr);
        dec_c.illegal = illegal;
        dec_c.rd      = (illegal || !has_rd) ? '0 : in_instr[11:7];
    end

    // Pipeline slot; flush beats accept and hold, operands refresh while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            if (flush)         valid_q <= 1'b0;
            else if (accept_c) valid_q <= 1'b1;
            else if (out_ready) valid_q <= 1'b0;

            if (accept_c) begin
                dec_q <= dec_c;
                rs1_q <= rf_rs1_c;
                rs2_q <= rf_rs2_c;
            end else if (hold_c && refresh_ok_c) begin
                if (wb_addr == dec_q.rs1) rs1_q <= wb_data;
                if (wb_addr == dec_q.rs2) rs2_q <= wb_data;
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = dec_q.pc;
    assign out_opcode   = dec_q.opcode;
    assign out_funct3   = dec_q.funct3;
    assign out_funct7   = dec_q.funct7;
    assign out_rd_addr  = dec_q.rd;
    assign out_rs1_data = rs1_q;
    assign out_rs2_data = rs2_q;
    assign out_imm      = dec_q.imm;
    assign out_illegal  = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, handshake, hold/refresh, bypass, flush and reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_ready;

    logic        in_ready,  m0_in_ready;
    logic        out_valid, m0_out_valid;
    logic [31:0] out_pc,    m0_out_pc;
    logic [6:0]  out_opcode, m0_out_opcode;
    logic [2:0]  out_funct3, m0_out_funct3;
    logic [6:0]  out_funct7, m0_out_funct7;
    logic [4:0]  out_rd_addr, m0_out_rd_addr;
    logic [31:0] out_rs1_data, m0_out_rs1_data;
    logic [31:0] out_rs2_data, m0_out_rs2_data;
    logic [31:0] out_imm, m0_out_imm;
    logic        out_illegal, m0_out_illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .M_EXT(1'b1), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd_addr(out_rd_addr), .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(32), .M_EXT(1'b0), .WB_BYPASS(1'b1)) dut_m0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m0_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(m0_out_valid), .out_ready(out_ready), .out_pc(m0_out_pc),
        .out_opcode(m0_out_opcode), .out_funct3(m0_out_funct3), .out_funct7(m0_out_funct7),
        .out_rd_addr(m0_out_rd_addr), .out_rs1_data(m0_out_rs1_data),
        .out_rs2_data(m0_out_rs2_data), .out_imm(m0_out_imm), .out_illegal(m0_out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    // Decode result check for the M_EXT=1 instance.
    task automatic chk_dec(input string tag, input logic [31:0] imm, input logic [4:0] rd,
                           input logic ill);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_imm"}, out_imm, imm);
        chk({tag, "_rd"}, 32'(out_rd_addr), 32'(rd));
        chk({tag, "_ill"}, 32'(out_illegal), 32'(ill));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_rs1", out_rs1_data, 32'd0);
        chk("rst_ill", 32'(out_illegal), 32'd0);
        chk("rst_op", 32'(out_opcode), 32'd0);
        rst = 1'b0;
        #1 chk("rst_ready", 32'(in_ready), 32'd1);

        wr(5'd5, 32'h0000_0007);
        wr(5'd6, 32'hFFFF_FFFD);

        issue(32'h4062_82B3, 32'h100);   // SUB x5,x5,x6
        chk_dec("sub", 32'd0, 5'd5, 1'b0);
        chk("sub_f7", 32'(out_funct7), 32'h20);
        chk("sub_f3", 32'(out_funct3), 32'd0);
        chk("sub_op", 32'(out_opcode), 32'h33);
        chk("sub_rs1", out_rs1_data, 32'd7);
        chk("sub_rs2", out_rs2_data, 32'hFFFF_FFFD);
        chk("sub_pc", out_pc, 32'h100);

        issue(32'hFFF0_0093, 32'h104);   // ADDI x1,x0,-1
        chk_dec("addi", 32'hFFFF_FFFF, 5'd1, 1'b0);
        chk("addi_rs1", out_rs1_data, 32'd0);
        issue(32'hFE00_0EE3, 32'h108);   // BEQ x0,x0,-4
        chk_dec("beq", 32'hFFFF_FFFC, 5'd0, 1'b0);
        issue(32'h1234_50B7, 32'h10C);   // LUI x1,0x12345
        chk_dec("lui", 32'h1234_5000, 5'd1, 1'b0);
        issue(32'hFE11_2C23, 32'h110);   // SW x1,-8(x2)
        chk_dec("sw", 32'hFFFF_FFF8, 5'd0, 1'b0);
        issue(32'hFFDF_F0EF, 32'h114);   // JAL x1,-4
        chk_dec("jal", 32'hFFFF_FFFC, 5'd1, 1'b0);
        issue(32'h4000_D093, 32'h118);   // SRAI x1,x1,0
        chk_dec("srai", 32'h0000_0400, 5'd1, 1'b0);
        issue(32'h4000_9093, 32'h11C);   // SLLI with funct7=0x20
        chk_dec("slli_bad", 32'h0000_0400, 5'd0, 1'b1);
        issue(32'h4000_1033, 32'h120);   // R funct7=0x20 funct3=1
        chk_dec("r_alt_f3", 32'd0, 5'd0, 1'b1);
        issue(32'h0000_02FF, 32'h124);   // opcode 0x7F, rd field 5
        chk_dec("op7f", 32'd0, 5'd0, 1'b1);

        issue(32'h0220_8033, 32'h128);   // MUL x0,x1,x2
        chk("mul_m1_ill", 32'(out_illegal), 32'd0);
        chk("mul_m0_ill", 32'(m0_out_illegal), 32'd1);
        chk("mul_m0_rd", 32'(m0_out_rd_addr), 32'd0);
        chk("mul_m0_valid", 32'(m0_out_valid), 32'd1);
        issue(32'h7F00_0033, 32'h12C);   // R funct7=0x3F
        chk("f7bad_ill", 32'(out_illegal), 32'd1);
        chk("f7bad_m0_ill", 32'(m0_out_illegal), 32'd1);

        // Hold three cycles with a refresh of x5, then release into back-to-back accept.
        issue(32'h4062_82B3, 32'h200);
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0020_81B3; in_pc = 32'h204;   // ADD x3,x1,x2
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
        #1 chk("hold_ready", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1'b0;
        chk("hold_refresh", out_rs1_data, 32'h55);
        chk("hold_rs2", out_rs2_data, 32'hFFFF_FFFD);
        chk("hold_pc1", out_pc, 32'h200);
        repeat (2) tick();
        chk("hold_pc3", out_pc, 32'h200);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_f7", 32'(out_funct7), 32'h20);
        chk("hold_rs1", out_rs1_data, 32'h55);

        out_ready = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
        #1 chk("rel_ready", 32'(in_ready), 32'd1);
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        chk("rel_pc", out_pc, 32'h204);
        chk("byp_rs1", out_rs1_data, 32'h1234);
        chk("rel_rs2", out_rs2_data, 32'd0);
        chk("rel_rd", 32'(out_rd_addr), 32'd3);

        // Write to x0 alongside an accept reading x0 and x1.
        in_valid = 1'b1; in_instr = 32'h0010_01B3; in_pc = 32'h208;   // ADD x3,x0,x1
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        chk("x0_rs1", out_rs1_data, 32'd0);
        chk("x1_rs2", out_rs2_data, 32'h1234);
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Flush a held instruction while fetch offers a new one.
        issue(32'hFFF0_0093, 32'h300);
        out_ready = 1'b0;
        chk("fl_pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h1234_50B7; in_pc = 32'h304;
        out_ready = 1'b1;
        #1 chk("fl_ready", 32'(in_ready), 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_noacc_pc", out_pc, 32'h300);
        tick();
        chk("fl_valid2", 32'(out_valid), 32'd0);

        // Reset while holding.
        issue(32'h4062_82B3, 32'h400);
        out_ready = 1'b0;
        #3 rst = 1'b1;
        #1 chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_pc", out_pc, 32'd0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 1; i < 32; i++) begin
            issue({7'd0, 5'(i), 5'(i), 3'd0, 5'd3, 7'h33}, 32'h500);
            chk($sformatf("mrst_x%0d", i), out_rs1_data, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
